// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int PC_INC       = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with push, pop and a flush that empties it in one cycle.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: none internally; pushes when full (without pop) and pops when empty are ignored.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_stage_p.sv
// Instruction fetch stage: in-order requests, response buffer, redirect with stale-response drop (FETCH_MISALIGN_CHK_EN adds a sticky misaligned-target halt).
// Latency: first dec_valid two cycles after reset release with 1-cycle memory; one instruction per cycle steady state.
// Backpressure: dec_ready low stalls the head; requests stop once in-flight plus buffered reach FIFO_DEPTH.
module fetch_stage_p
    import fetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_4,
    output logic            misalign
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int UW = CW + 1;

    // Same field order as fetch_entry_t, sized by XLEN.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   aq_count;
    logic [XLEN-1:0] aq_head;
    logic [UW-1:0]   in_use;
    logic            req_fire;
    logic            dropping;
    logic            rsp_keep;
    logic            pop;
    logic            halt;
    entry_t          push_entry;
    entry_t          head;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (pc_src && (pc_target[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end

    assign misalign  = misalign_q;
    assign halt      = misalign_q;
    assign target_pc = pc_target;
`else
    assign misalign  = 1'b0;
    assign halt      = 1'b0;
    assign target_pc = pc_target & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif

    assign dec_valid = (occupancy != '0);
    assign pop       = dec_valid && dec_ready && !pc_src;
    assign dropping  = (drop_cnt != '0);
    assign rsp_keep  = imem_rsp_valid && !pc_src && !dropping && (aq_count != '0);
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign imem_addr = fetch_pc;

    // The slot freed by this cycle's pop counts as available, otherwise a
    // depth-2 buffer could only sustain one instruction every other cycle.
    assign in_use = {1'b0, outstanding} + {1'b0, occupancy} - UW'(pop);
    assign imem_req_valid = !pc_src && !halt && (in_use < UW'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_VEC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (pc_src)
                fetch_pc <= target_pc;
            else if (req_fire)
                fetch_pc <= fetch_pc + XLEN'(PC_INC);

            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

            // A response landing in the redirect cycle is discarded here, so it
            // is not counted among the stale ones still to come.
            if (pc_src)
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && dropping)
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Stale responses never pop the address queue; it was flushed on redirect.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_q (
        .clk      (clk),
        .rst      (rst),
        .push     (req_fire),
        .push_dat (fetch_pc),
        .pop      (rsp_keep),
        .flush    (pc_src),
        .head_dat (aq_head),
        .count    (aq_count)
    );

    assign push_entry.instr = imem_rsp_data;
    assign push_entry.pc    = aq_head;
    assign push_entry.pc_4  = aq_head + XLEN'(PC_INC);

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_entry_q (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_keep),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (pc_src),
        .head_dat (head),
        .count    (occupancy)
    );

    assign instr = dec_valid ? head.instr : '0;
    assign pc    = dec_valid ? head.pc    : '0;
    assign pc_4  = dec_valid ? head.pc_4  : '0;

endmodule

// File: tb/tb_fetch_stage_p.sv
// Self-checking bench for fetch_stage_p: in-order memory model with configurable latency and
// a scoreboard of expected decode entries pushed on each response and popped on each decode handshake.
module tb_fetch_stage_p;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        misalign;

    fetch_stage_p #(
        .XLEN       (32),
        .RESET_VEC  (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .instr          (instr),
        .pc             (pc),
        .pc_4           (pc_4),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t        mem_q[$];
    fetch_entry_t exp_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pop_cnt = 0;
    int          first_vld = -1;
    logic [31:0] exp_fetch_pc = '0;
    bit          exp_mis = 1'b0;
    bit          pop_seen = 1'b0;
    logic [31:0] pop_pc = '0;
    logic [31:0] pop_pc4 = '0;
    bit          obs_dec_valid;
    bit          obs_req_valid;
    logic [31:0] obs_addr;
    bit          obs_mis;
    bit          wrap_seen = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pc_src = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_q.delete();
        exp_q.delete();
        exp_fetch_pc = 32'h0;
        exp_mis = 1'b0;
        pop_cnt = 0;
        first_vld = -1;
        #1;
        check_val("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check_val("rst_instr", instr, 32'd0);
        check_val("rst_pc", pc, 32'd0);
        check_val("rst_pc_4", pc_4, 32'd0);
        check_val("rst_misalign", {31'b0, misalign}, 32'd0);
        check_val("rst_addr", imem_addr, 32'd0);
        cyc = 0;
    endtask

    task automatic step(input bit redir, input logic [31:0] tgt, input bit drdy, input bit mrdy);
        mreq_t r;
        bit    rsp_now;
        @(negedge clk);
        rst = 1'b0;
        pc_src = redir;
        pc_target = tgt;
        dec_ready = drdy;
        imem_req_ready = mrdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        rsp_now = 1'b0;
        r = '{addr: 32'h0, due: 0, stale: 1'b0};
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_word(r.addr);
            rsp_now = 1'b1;
        end
        #1;
        obs_dec_valid = dec_valid;
        obs_req_valid = imem_req_valid;
        obs_addr = imem_addr;
        obs_mis = misalign;

        check_val("dec_valid", {31'b0, dec_valid}, {31'b0, exp_q.size() != 0});
        if (dec_valid && exp_q.size() > 0) begin
            check_val("head_instr", instr, exp_q[0].instr);
            check_val("head_pc", pc, exp_q[0].pc);
            check_val("head_pc_4", pc_4, exp_q[0].pc_4);
        end
        check_val("inflight_bound", {31'b0, (mem_q.size() + int'(rsp_now) + exp_q.size()) <= DEPTH}, 32'd1);
        if (redir)
            check_val("req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
        if (exp_mis)
            check_val("req_after_misalign", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid)
            check_val("req_addr", imem_addr, exp_fetch_pc);
        check_val("misalign", {31'b0, misalign}, {31'b0, exp_mis});

        if (dec_valid && first_vld < 0)
            first_vld = cyc;
        if (dec_valid && drdy && !redir && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            pop_cnt++;
            pop_seen = 1'b1;
            pop_pc = pc;
            pop_pc4 = pc_4;
        end
        if (rsp_now && !redir && !r.stale)
            exp_q.push_back('{instr: mem_word(r.addr), pc: r.addr, pc_4: r.addr + 32'd4});
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
            exp_fetch_pc = tgt;
`else
            exp_fetch_pc = tgt & 32'hFFFF_FFFC;
`endif
        end else if (imem_req_valid && mrdy) begin
            mem_q.push_back('{addr: exp_fetch_pc, due: cyc + lat, stale: 1'b0});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, 1-cycle memory, decode always ready.
        lat = 1;
        do_reset();
        for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("first_vld_cycle", first_vld, 32'd2);
        check_val("throughput_pops", pop_cnt, 32'd22);

        // Decode stall for 5 cycles, then release.
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("stall_req_stopped", {31'b0, obs_req_valid}, 32'd0);
        check_val("stall_dec_valid", {31'b0, obs_dec_valid}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // 3-cycle memory, redirect with two requests in flight.
        lat = 3;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("two_in_flight", mem_q.size(), 32'd2);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        pop_seen = 1'b0;
        for (int i = 0; i < 30 && !pop_seen; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("redir_pop_seen", {31'b0, pop_seen}, 32'd1);
        check_val("redir_first_pc", pop_pc, 32'h100);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("flush_empty", {31'b0, obs_dec_valid}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            pop_seen = 1'b0;
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (pop_seen && pop_pc == 32'hFFFF_FFFC) begin
                wrap_seen = 1'b1;
                check_val("wrap_pc_4", pop_pc4, 32'h0);
            end
        end
        check_val("wrap_seen", {31'b0, wrap_seen}, 32'd1);

        // Random handshakes with occasional redirects.
        lat = 2;
        for (int i = 0; i < 250; i++) begin
            bit redir;
            redir = ($urandom_range(19) == 0);
            step(redir, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(1)), 1'($urandom_range(3) != 0));
        end

        // Reset mid-operation discards buffered entries; then normal fetch resumes.
        lat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned redirect target.
        step(1'b1, 32'h102, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef FETCH_MISALIGN_CHK_EN
        check_val("mis_flag", {31'b0, obs_mis}, 32'd1);
        check_val("mis_req_off", {31'b0, obs_req_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("mis_sticky", {31'b0, obs_mis}, 32'd1);
`else
        check_val("mis_flag", {31'b0, obs_mis}, 32'd0);
        check_val("mis_req_on", {31'b0, obs_req_valid}, 32'd1);
        check_val("mis_addr", obs_addr, 32'h100);
        pop_seen = 1'b0;
        for (int i = 0; i < 10 && !pop_seen; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("mis_first_pc", pop_pc, 32'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
